gdeconv_output_transform: RTL and testbench
===========================================

// Module: gdeconv_output_transform
// PURPOSE
// - Inverse-side partner of the GDeConv weight transform (G w G^T, 4x4 -> 6x6).
// - Accumulates 6x6 Winograd-domain product tiles across input channels.
// - Applies the output transform Y = AT * M * AT^T (6x6 -> 4x4 spatial tile).
// - Sits between the elementwise-multiply array and the output writeback buffer.
// - AT is the fixed 4x6 0/1 matrix (AT = G^T); rows are:
//     r0 = {0,0,0,0,1,1}   r1 = {0,1,1,0,0,0}
//     r2 = {0,0,0,1,1,0}   r3 = {1,1,0,0,0,0}
// PARAMETERS
// - ACC_W    24  width of each incoming product element (signed)
// - CH_LOG2  6   log2 of max channel tiles accumulated per output tile
// - SUM_W    ACC_W+CH_LOG2  accumulator element width (signed)
// - OUT_W    SUM_W+2        output element width (signed; each Y is a sum of 4 terms)
// PORTS
// - clk      in   1                clock, rising edge
// - rst      in   1                reset, asynchronous, active-high
// - s_valid  in   1                input row valid
// - s_ready  out  1                input row accepted when s_valid & s_ready
// - s_row    in   [0:5] x ACC_W    one 6-element row of the product tile (signed)
// - s_last   in   1                current tile is the last channel; sampled on row 5 only
// - m_valid  out  1                output tile valid
// - m_ready  in   1                downstream accepts the tile
// - m_tile   out  [0:3][0:3] x OUT_W  transformed 4x4 output tile (signed)
// - busy     out  1                high whenever state != ACCUM or row_cnt != 0
// BEHAVIOUR
// - Reset (async, rst=1) values:
//   - state=ACCUM, row_cnt=0, first=1, acc=0, T=0.
//   - m_valid=0, m_tile=0, s_ready=1 after reset release, busy=0.
// - FSM states: ACCUM -> XROW -> XCOL -> OUT -> ACCUM.
// - ACCUM:
//   - s_ready=1. A row is accepted on a clock edge where s_valid=1.
//   - Accepted row updates acc[row_cnt][*]: load if first=1, else add (sign-extended to SUM_W).
//   - row_cnt increments and wraps 5 -> 0.
//   - On accepting row 5: first <= s_last. If s_last=1, go to XROW; else stay in ACCUM.
// - XROW: s_ready=0. Register T[i][l] = sum_k AT[i][k]*acc[k][l] (4x6, SUM_W+1 bits).
// - XCOL: s_ready=0. Register m_tile[i][j] = sum_l T[i][l]*AT[j][l], then m_valid <= 1.
// - Latency: m_valid rises on the 2nd clock edge after the edge that accepts row 5 with s_last=1.
// - OUT:
//   - s_ready=0; m_valid and m_tile are held stable until m_ready=1.
//   - On m_valid & m_ready: m_valid <= 0, first <= 1, state <= ACCUM.
//   - The next tile's row 0 may be accepted on the following edge.
// - Arithmetic: two's complement, wraps modulo 2^SUM_W in acc and 2^OUT_W out; no saturation.
// - More than 2^CH_LOG2 channel tiles: accumulation wraps; no error flag.
// - s_last on rows 0-4 is ignored.
// - s_valid while s_ready=0: ignored; the upstream must hold the row.
// - Reset mid-tile or mid-output:
//   - All partial sums and any pending output are discarded.
//   - The next accepted row is row 0 of a fresh accumulation.
// CONFIGURATION
// - GDECONV_OT_RELU_EN defined: in XCOL each Y element is clamped to 0 if negative before registering.
// - GDECONV_OT_RELU_EN undefined: m_tile carries the signed result unmodified.
// - Latency and handshake are identical in both builds.
// TESTING
// - Single tile, all 36 elements = 1, s_last=1:
//   - m_valid 2 edges after row 5; all 16 Y = 4.
// - Single tile, M[0][0]=7, others 0:
//   - Y[3][3]=7; all other Y = 0.
// - 3 channel tiles, all elements 1; s_last only on tile 3:
//   - all Y = 12; s_ready stays 1 across tile boundaries.
// - Backpressure: m_ready=0 for 5 cycles after m_valid:
//   - m_valid and m_tile held, s_ready=0, busy=1.
//   - Tile consumed on the first m_ready=1 edge; s_ready=1 next cycle.
// - All elements = -1, single tile:
//   - Y = -4 without GDECONV_OT_RELU_EN; Y = 0 with it.
// - rst pulsed after 3 rows accepted, then a full all-ones tile with s_last=1:
//   - all Y = 4 (no residue); m_valid=0 throughout the reset.

Source files
------------

// File: rtl/gdeconv_output_transform.sv
`default_nettype none
// ============================================================================
//  Module      : gdeconv_output_transform
//  Description : Accumulates 6x6 Winograd-domain product tiles across input
//                channels, then applies the output transform
//                Y = AT * M * AT^T to produce a 4x4 spatial tile.
//                AT is the fixed 4x6 0/1 matrix (AT = G^T) with rows
//                  r0={0,0,0,0,1,1} r1={0,1,1,0,0,0}
//                  r2={0,0,0,1,1,0} r3={1,1,0,0,0,0}
//  Ports       : clk, rst            clock / async active-high reset
//                s_valid/s_ready     input row handshake
//                s_row               one 6-element signed product row
//                s_last              last channel tile (sampled on row 5)
//                m_valid/m_ready     output tile handshake
//                m_tile              4x4 signed output tile
//                busy                tile in flight
//  Options     : GDECONV_OT_RELU_EN  clamp negative outputs to zero
//  Revision    : 1.0  initial release
// ============================================================================
module gdeconv_output_transform #(
    parameter int ACC_W   = 24,
    parameter int CH_LOG2 = 6,
    parameter int SUM_W   = ACC_W + CH_LOG2,
    parameter int OUT_W   = SUM_W + 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [0:5][ACC_W-1:0]          s_row,
    input  logic                           s_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [0:3][0:3][OUT_W-1:0]     m_tile,
    output logic                           busy
);

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_XROW  = 2'd1,
        S_XCOL  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Every AT row holds exactly two ones, so a product with AT reduces to
    // a pair-sum. These tables give the column indices of the two ones.
    localparam int c_AT_LO [0:3] = '{4, 1, 3, 0};
    localparam int c_AT_HI [0:3] = '{5, 2, 4, 1};

    state_t                         r_state;
    logic [2:0]                     r_row_cnt;
    logic                           r_first;
    logic [SUM_W-1:0]               r_acc [0:5][0:5];
    logic [SUM_W:0]                 r_t   [0:3][0:5];
    logic [0:3][0:3][OUT_W-1:0]     r_m_tile;
    logic                           r_m_valid;

    logic [SUM_W-1:0]               w_row_ext [0:5];
    logic [SUM_W:0]                 w_t       [0:3][0:5];
    logic [OUT_W-1:0]               w_y       [0:3][0:3];

    assign s_ready = (r_state == S_ACCUM);
    assign busy    = (r_state != S_ACCUM) || (r_row_cnt != 3'd0);
    assign m_valid = r_m_valid;
    assign m_tile  = r_m_tile;

    always_comb begin
        for (int c = 0; c < 6; c++) begin
            w_row_ext[c] = {{(SUM_W-ACC_W){s_row[c][ACC_W-1]}}, s_row[c]};
        end
        // Row transform: T = AT * acc (4x6), one growth bit.
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 6; l++) begin
                w_t[i][l] = {r_acc[c_AT_LO[i]][l][SUM_W-1], r_acc[c_AT_LO[i]][l]}
                          + {r_acc[c_AT_HI[i]][l][SUM_W-1], r_acc[c_AT_HI[i]][l]};
            end
        end
        // Column transform: Y = T * AT^T (4x4), one more growth bit.
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_y[i][j] = {r_t[i][c_AT_LO[j]][SUM_W], r_t[i][c_AT_LO[j]]}
                          + {r_t[i][c_AT_HI[j]][SUM_W], r_t[i][c_AT_HI[j]]};
`ifdef GDECONV_OT_RELU_EN
                if (w_y[i][j][OUT_W-1]) begin
                    w_y[i][j] = '0;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_ACCUM;
            r_row_cnt <= 3'd0;
            r_first   <= 1'b1;
            r_m_valid <= 1'b0;
            r_m_tile  <= '0;
            for (int r = 0; r < 6; r++) begin
                for (int c = 0; c < 6; c++) begin
                    r_acc[r][c] <= '0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int l = 0; l < 6; l++) begin
                    r_t[i][l] <= '0;
                end
            end
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (s_valid) begin
                        // First channel of a tile overwrites stale sums.
                        for (int c = 0; c < 6; c++) begin
                            r_acc[r_row_cnt][c] <= r_first ? w_row_ext[c]
                                                 : r_acc[r_row_cnt][c] + w_row_ext[c];
                        end
                        if (r_row_cnt == 3'd5) begin
                            r_row_cnt <= 3'd0;
                            r_first   <= s_last;
                            if (s_last) begin
                                r_state <= S_XROW;
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + 3'd1;
                        end
                    end
                end
                S_XROW: begin
                    for (int i = 0; i < 4; i++) begin
                        for (int l = 0; l < 6; l++) begin
                            r_t[i][l] <= w_t[i][l];
                        end
                    end
                    r_state <= S_XCOL;
                end
                S_XCOL: begin
                    for (int i = 0; i < 4; i++) begin
                        for (int j = 0; j < 4; j++) begin
                            r_m_tile[i][j] <= w_y[i][j];
                        end
                    end
                    r_m_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_first   <= 1'b1;
                        r_state   <= S_ACCUM;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gdeconv_output_transform.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gdeconv_output_transform
//  Description : Directed self-checking bench for gdeconv_output_transform.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gdeconv_output_transform;

    localparam int ACC_W   = 24;
    localparam int CH_LOG2 = 6;
    localparam int SUM_W   = ACC_W + CH_LOG2;
    localparam int OUT_W   = SUM_W + 2;

    logic                       clk;
    logic                       rst;
    logic                       s_valid;
    logic                       s_ready;
    logic [0:5][ACC_W-1:0]      s_row;
    logic                       s_last;
    logic                       m_valid;
    logic                       m_ready;
    logic [0:3][0:3][OUT_W-1:0] m_tile;
    logic                       busy;

    int n_checks = 0;
    int n_pass   = 0;

    gdeconv_output_transform #(
        .ACC_W   (ACC_W),
        .CH_LOG2 (CH_LOG2),
        .SUM_W   (SUM_W),
        .OUT_W   (OUT_W)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_row   (s_row),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_tile  (m_tile),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] got,
                         input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives six back-to-back rows; element [0][0] may differ from the rest.
    task automatic send_tile(input int v, input int v00, input bit last,
                             input string tag);
        for (int r = 0; r < 6; r++) begin
            s_valid = 1'b1;
            s_last  = last;
            for (int c = 0; c < 6; c++) begin
                s_row[c] = (r == 0 && c == 0) ? ACC_W'(v00) : ACC_W'(v);
            end
            check($sformatf("%s_s_ready_r%0d", tag, r), OUT_W'(s_ready), OUT_W'(1));
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_row   = '0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!m_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, OUT_W'(n), OUT_W'(2));
    endtask

    task automatic check_tile(input string tag, input int e, input int e33);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                check($sformatf("%s_y%0d%0d", tag, i, j), m_tile[i][j],
                      (i == 3 && j == 3) ? OUT_W'(e33) : OUT_W'(e));
            end
        end
    endtask

    task automatic consume(input string tag);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check({tag, "_m_valid_low"}, OUT_W'(m_valid), OUT_W'(0));
        check({tag, "_s_ready_back"}, OUT_W'(s_ready), OUT_W'(1));
        check({tag, "_busy_low"}, OUT_W'(busy), OUT_W'(0));
    endtask

    initial begin
        int relu_exp;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_row   = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_m_valid", OUT_W'(m_valid), OUT_W'(0));
        check("rst_s_ready", OUT_W'(s_ready), OUT_W'(1));
        check("rst_busy", OUT_W'(busy), OUT_W'(0));
        check("rst_m_tile_or", OUT_W'(|m_tile), OUT_W'(0));

        // All ones, single tile: Y = 4
        send_tile(1, 1, 1'b1, "ones");
        check("ones_busy_after_row5", OUT_W'(busy), OUT_W'(1));
        check("ones_s_ready_after_row5", OUT_W'(s_ready), OUT_W'(0));
        wait_out("ones");
        check_tile("ones", 4, 4);
        consume("ones");

        // Single impulse at M[0][0]: only Y[3][3] picks it up
        send_tile(0, 7, 1'b1, "imp");
        wait_out("imp");
        check_tile("imp", 0, 7);
        consume("imp");

        // Three channel tiles of ones: Y = 12, no bubbles between tiles
        send_tile(1, 1, 1'b0, "ch1");
        send_tile(1, 1, 1'b0, "ch2");
        send_tile(1, 1, 1'b1, "ch3");
        wait_out("ch3");
        check_tile("ch3", 12, 12);
        consume("ch3");

        // Backpressure: output held for 5 cycles, stray s_valid is ignored
        send_tile(1, 1, 1'b1, "bp");
        wait_out("bp");
        s_valid = 1'b1;
        for (int c = 0; c < 6; c++) s_row[c] = ACC_W'(9);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_m_valid_c%0d", k), OUT_W'(m_valid), OUT_W'(1));
            check($sformatf("bp_s_ready_c%0d", k), OUT_W'(s_ready), OUT_W'(0));
            check($sformatf("bp_busy_c%0d", k), OUT_W'(busy), OUT_W'(1));
            check($sformatf("bp_y00_c%0d", k), m_tile[0][0], OUT_W'(4));
        end
        check_tile("bp", 4, 4);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_row   = '0;
        check("bp_m_valid_low", OUT_W'(m_valid), OUT_W'(0));
        check("bp_s_ready_back", OUT_W'(s_ready), OUT_W'(1));
        check("bp_busy_low", OUT_W'(busy), OUT_W'(0));
        send_tile(1, 1, 1'b1, "post_bp");
        wait_out("post_bp");
        check_tile("post_bp", 4, 4);
        consume("post_bp");

        // All -1: Y = -4, or 0 when the clamp is built in
`ifdef GDECONV_OT_RELU_EN
        relu_exp = 0;
`else
        relu_exp = -4;
`endif
        send_tile(-1, -1, 1'b1, "neg");
        wait_out("neg");
        check_tile("neg", relu_exp, relu_exp);
        consume("neg");

        // Reset after 3 rows of 5s; the following all-ones tile must be clean
        for (int r = 0; r < 3; r++) begin
            s_valid = 1'b1;
            for (int c = 0; c < 6; c++) s_row[c] = ACC_W'(5);
            tick();
        end
        s_valid = 1'b0;
        s_row   = '0;
        check("mid_busy_before_rst", OUT_W'(busy), OUT_W'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_m_valid_async", OUT_W'(m_valid), OUT_W'(0));
        check("mid_rst_busy_async", OUT_W'(busy), OUT_W'(0));
        tick();
        check("mid_rst_m_valid", OUT_W'(m_valid), OUT_W'(0));
        rst = 1'b0;
        tick();
        check("mid_rst_s_ready", OUT_W'(s_ready), OUT_W'(1));
        send_tile(1, 1, 1'b1, "after_rst");
        wait_out("after_rst");
        check_tile("after_rst", 4, 4);
        consume("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
